// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the icache (read-only)
// and the dcache (read/write, 2-word blocks). A dcache grant is held across
// a block; a starvation counter forces an icache grant at a block boundary
// once the icache has waited through STARVE_LIMIT dcache word completions.
//
// state  | meaning
// IDLE   | no grant, nothing driven to the RAM, both waits high
// IGRANT | icache owns the RAM, read of iaddr in progress
// DGRANT | dcache owns the RAM, held until a block boundary or dreq drops
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [1:0]        busy_owner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             dreq, access, i_done, d_done, d_boundary;

  assign dreq       = dREN | dWEN;
  assign access     = (ramstate == RAM_ACCESS);
  assign i_done     = (state == IGRANT) && access;
  assign d_done     = (state == DGRANT) && access && dreq;
  assign d_boundary = d_done && daddr[2];

  // Starvation count: ERROR/BUSY cycles never complete a word, so only
  // ACCESS cycles move it; any gap in iREN means the icache is not starving.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!iREN)
      starve_nxt = '0;
    else if (i_done)
      starve_nxt = '0;
    else if (d_done && (starve_cnt < LIMIT))
      starve_nxt = starve_cnt + CNT_W'(1);
  end

  // Grant decision; the boundary check sees the count including this word.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dreq && !(iREN && (starve_cnt >= LIMIT)))
          state_nxt = DGRANT;
        else if (iREN)
          state_nxt = IGRANT;
      end
      IGRANT: begin
        if (i_done)
          state_nxt = dreq ? DGRANT : (iREN ? IGRANT : IDLE);
        else if (!iREN)
          state_nxt = IDLE;
      end
      DGRANT: begin
        if (!dreq)
          state_nxt = iREN ? IGRANT : IDLE;
        else if (d_boundary && iREN && (starve_nxt >= LIMIT))
          state_nxt = IGRANT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and starvation counter; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // RAM drive and wait release follow the current grant; a write beats a read.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = !i_done;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !d_done;
      end
      default: ;
    endcase
  end

  assign iload      = ramload;
  assign dload      = ramload;
  assign busy_owner = state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port RAM between the icache (read-only) and the dcache (read/write, 2-word block transfers).
- Sits between the two caches and the RAM model/controller.
- Returns per-requester wait/load signals.
- Holds a grant across a dcache block transfer.
- Bounds icache starvation with a counter.

Parameters:
- STARVE_LIMIT, 4, consecutive dcache word completions allowed while icache is waiting before icache gets priority at the next block boundary
- ADDR_W, 32, address width in bits
- DATA_W, 32, data word width in bits

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  high unless the icache word completes this cycle
- iload  out  DATA_W  RAM read data to the icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  high unless the dcache word completes this cycle
- dload  out  DATA_W  RAM read data to the dcache
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- busy_owner  out  2  current grant: 0 none, 1 icache, 2 dcache (debug/verification)

Behaviour:
- States: IDLE, IGRANT, DGRANT. Reset (RST high at a clock edge) gives:
  - state=IDLE, starve_cnt=0
  - all ram enables low, iwait=dwait=1, busy_owner=0, ramaddr/ramstore=0
- RST dominates all requests on the same edge, including mid-transfer. An in-flight RAM access is abandoned and no wait is released.
- Outputs are combinational from state and inputs. Grant decisions are registered.
- iload=dload=ramload at all times. Only the granted requester sees wait low.
- dreq = dREN|dWEN. If dREN and dWEN are both high, the write wins: ramWEN=1, ramREN=0.
- IDLE:
  - Nothing is driven to the RAM. Both waits are high.
  - If dreq and not (iREN and starve_cnt>=STARVE_LIMIT), go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
  - Arbitration costs exactly one cycle from IDLE.
- IGRANT:
  - ramREN=1, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 for that cycle, starve_cnt cleared to 0.
  - Next state on completion: DGRANT if dreq, else IGRANT if iREN, else IDLE. Re-grant is direct, with no IDLE bubble.
  - If iREN drops without completion, go to IDLE.
- DGRANT:
  - ramREN/ramWEN from dREN/dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0. If iREN is high, starve_cnt increments, saturating at STARVE_LIMIT.
  - The grant is held while dreq remains high.
  - Release happens only at a block boundary, i.e. a completion with daddr[2]==1. At a boundary:
    - If iREN and starve_cnt>=STARVE_LIMIT, go to IGRANT.
    - Else stay in DGRANT if dreq is still high.
    - Else go to IGRANT if iREN, else IDLE.
  - If dreq drops at any time, go to IGRANT if iREN, else IDLE. This covers the halt/flush sequence ending early.
- ramstate handling:
  - BUSY/FREE: hold the current drive. ACCESS: completion.
  - ERROR: treated as BUSY; the request stays pending and the wait stays high.
- starve_cnt is cleared whenever iREN is low.
- busy_owner reflects the state encoding.

Test Plan:
- Reset: RST high 2 cycles with iREN=dREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, busy_owner=0. First grant is DGRANT one cycle after RST falls.
- Simultaneous requests: iREN=1 iaddr=0x100, dREN=1 daddr=0x40, ramstate ACCESS after 2 BUSY cycles:
  - dcache served first: ramaddr=0x40, dwait low one cycle, dload=ramload.
  - dREN then low -> IGRANT with no IDLE cycle; ramaddr=0x100.
- Block hold: dWEN at daddr=0x80 then 0x84, iREN=1 throughout -> both dcache words complete before any ramaddr=iaddr; iwait stays 1 until the 0x84 completion.
- Starvation: STARVE_LIMIT=4, dcache issues 3 back-to-back blocks, iREN=1 -> after 4 dcache completions, the next grant at the block boundary (after word 0x..4) is IGRANT; starve_cnt returns to 0 on icache completion.
- Write priority and ERROR: dREN=dWEN=1, daddr=0x20, dstore=0xDEADBEEF, ramstate=ERROR for 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dwait=1 for 3 cycles then 0.
- Mid-transfer reset: RST asserted in DGRANT after word 0x80 completes, before 0x84 -> next cycle is IDLE, ramWEN=0, dwait=1, busy_owner=0.
